// File: rtl/mult_div_unit_if.sv
// Handshake and data bundle between the control FSM and the multiply/divide engine.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_zero_exc;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, hi_out, lo_out, div_zero_exc
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, hi_out, lo_out, div_zero_exc
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle Booth multiplier / restoring divider producing HI:LO.
// Define MULTDIV_UNSIGNED_EN to honour op[1] as the unsigned (multu/divu) select.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_RUN,
        S_DIV_RUN,
        S_FIN,
        S_ZERO
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               is_div_q, is_div_d;
    logic               uns_q, uns_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               uns_sel;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     ext_upper, ext_m, mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH:0]   mul_next, div_next;
    logic [WIDTH-1:0]   quo, rem;

`ifdef MULTDIV_UNSIGNED_EN
    assign uns_sel = bus.op[1];
`else
    logic unused_op_hi;
    assign uns_sel      = 1'b0;
    assign unused_op_hi = bus.op[1];
`endif

    assign a_neg = ~uns_sel & bus.a_in[WIDTH-1];
    assign b_neg = ~uns_sel & bus.b_in[WIDTH-1];
    assign a_mag = a_neg ? -bus.a_in : bus.a_in;
    assign b_mag = b_neg ? -bus.b_in : bus.b_in;

    // Sum is one bit wider than the upper half so the most negative multiplicand
    // cannot overflow before the arithmetic shift folds it back to WIDTH bits.
    always_comb begin
        ext_upper = {~uns_q & acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
        ext_m     = {~uns_q & m_q[WIDTH-1], m_q};
        mul_sum   = ext_upper;
        if (uns_q) begin
            if (acc_q[1]) mul_sum = ext_upper + ext_m;
        end else begin
            case (acc_q[1:0])
                2'b01:   mul_sum = ext_upper + ext_m;
                2'b10:   mul_sum = ext_upper - ext_m;
                default: mul_sum = ext_upper;
            endcase
        end
        mul_next = {mul_sum, acc_q[WIDTH:1]};

        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m_q};
        div_ge    = ~div_diff[WIDTH];
        div_next  = {1'b0, div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0],
                     acc_q[WIDTH-2:0], div_ge};

        quo = acc_q[WIDTH-1:0];
        rem = acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        m_d      = m_q;
        is_div_d = is_div_q;
        uns_d    = uns_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        case (state_q)
            // ZERO behaves like IDLE so a start in its done cycle is accepted.
            S_IDLE, S_ZERO: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    if (bus.op[0] && (bus.b_in == '0)) begin
                        state_d = S_ZERO;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                    end else begin
                        cnt_d    = CW'(WIDTH - 1);
                        is_div_d = bus.op[0];
                        uns_d    = uns_sel;
                        if (bus.op[0]) begin
                            state_d = S_DIV_RUN;
                            acc_d   = {{(WIDTH+1){1'b0}}, a_mag};
                            m_d     = b_mag;
                            q_neg_d = a_neg ^ b_neg;
                            r_neg_d = a_neg;
                        end else begin
                            state_d = S_MUL_RUN;
                            acc_d   = {{WIDTH{1'b0}}, bus.b_in, 1'b0};
                            m_d     = bus.a_in;
                            q_neg_d = 1'b0;
                            r_neg_d = 1'b0;
                        end
                    end
                end
            end
            S_MUL_RUN: begin
                acc_d = mul_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = S_FIN;
            end
            S_DIV_RUN: begin
                acc_d = div_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = S_FIN;
            end
            S_FIN: begin
                if (is_div_q) begin
                    hi_d = r_neg_q ? -rem : rem;
                    lo_d = q_neg_q ? -quo : quo;
                end else begin
                    hi_d = acc_q[2*WIDTH:WIDTH+1];
                    lo_d = acc_q[WIDTH:1];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            m_q      <= '0;
            is_div_q <= 1'b0;
            uns_q    <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            m_q      <= m_d;
            is_div_q <= is_div_d;
            uns_q    <= uns_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.busy         = (state_q == S_MUL_RUN) || (state_q == S_DIV_RUN);
    assign bus.done         = done_q;
    assign bus.div_zero_exc = dz_q;
    assign bus.hi_out       = hi_q;
    assign bus.lo_out       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (signed and, with MULTDIV_UNSIGNED_EN, unsigned ops).
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Leaves the bench 1 time unit after the start edge S.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Returns the number of edges after S at which done was seen, or -1 on timeout.
    task automatic wait_done(output int k);
        k = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b expected 0", bus.done); else passed++;
        total++; if (bus.div_zero_exc !== 1'b0) $display("FAIL rst_dz: got %b expected 0", bus.div_zero_exc); else passed++;
        total++; if (bus.hi_out !== 32'h0) $display("FAIL rst_hi: got %h expected 00000000", bus.hi_out); else passed++;
        total++; if (bus.lo_out !== 32'h0) $display("FAIL rst_lo: got %h expected 00000000", bus.lo_out); else passed++;
    endtask

    task automatic test_mult_latency;
        int   k;
        logic busy0, busy31, busy32, hi_early;
        k = -1;
        busy31 = 1'b0;
        busy32 = 1'b1;
        hi_early = 1'b0;
        launch(2'b00, 32'd7, 32'hFFFF_FFFD);
        busy0 = bus.busy;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (i == 31) busy31 = bus.busy;
            if (i == 32) busy32 = bus.busy;
            if (!bus.done && (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0)) hi_early = 1'b1;
            if (bus.done) begin
                k = i;
                break;
            end
        end
        total++; if (busy0 !== 1'b1) $display("FAIL mul_busy_first: got %b expected 1", busy0); else passed++;
        total++; if (busy31 !== 1'b1) $display("FAIL mul_busy_last_run: got %b expected 1", busy31); else passed++;
        total++; if (busy32 !== 1'b0) $display("FAIL mul_busy_fin: got %b expected 0", busy32); else passed++;
        total++; if (hi_early !== 1'b0) $display("FAIL mul_no_partial: got %b expected 0", hi_early); else passed++;
        total++; if (k !== 33) $display("FAIL mul_latency: got %0d expected 33", k); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL mul_busy_at_done: got %b expected 0", bus.busy); else passed++;
        total++; if (bus.hi_out !== 32'hFFFF_FFFF) $display("FAIL mul_hi: got %h expected ffffffff", bus.hi_out); else passed++;
        total++; if (bus.lo_out !== 32'hFFFF_FFEB) $display("FAIL mul_lo: got %h expected ffffffeb", bus.lo_out); else passed++;
        total++; if (bus.div_zero_exc !== 1'b0) $display("FAIL mul_dz: got %b expected 0", bus.div_zero_exc); else passed++;
        @(posedge clk);
        #1;
        total++; if (bus.done !== 1'b0) $display("FAIL mul_done_pulse: got %b expected 0", bus.done); else passed++;
        total++; if (bus.lo_out !== 32'hFFFF_FFEB) $display("FAIL mul_lo_hold: got %h expected ffffffeb", bus.lo_out); else passed++;
    endtask

    task automatic test_div_signed;
        int k;
        launch(2'b01, 32'hFFFF_FFF9, 32'd2);
        wait_done(k);
        total++; if (k !== 33) $display("FAIL div_latency: got %0d expected 33", k); else passed++;
        total++; if (bus.lo_out !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h expected fffffffd", bus.lo_out); else passed++;
        total++; if (bus.hi_out !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h expected ffffffff", bus.hi_out); else passed++;
        total++; if (bus.div_zero_exc !== 1'b0) $display("FAIL div_dz: got %b expected 0", bus.div_zero_exc); else passed++;
    endtask

    task automatic test_div_zero;
        int k;
        launch(2'b01, 32'h0000_0451, 32'h0000_0020);
        wait_done(k);
        total++; if (bus.lo_out !== 32'h22) $display("FAIL pre_lo: got %h expected 00000022", bus.lo_out); else passed++;
        total++; if (bus.hi_out !== 32'h11) $display("FAIL pre_hi: got %h expected 00000011", bus.hi_out); else passed++;
        launch(2'b01, 32'd5, 32'd0);
        total++; if (bus.done !== 1'b1) $display("FAIL dz_done: got %b expected 1", bus.done); else passed++;
        total++; if (bus.div_zero_exc !== 1'b1) $display("FAIL dz_exc: got %b expected 1", bus.div_zero_exc); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL dz_busy: got %b expected 0", bus.busy); else passed++;
        total++; if (bus.hi_out !== 32'h11) $display("FAIL dz_hi_hold: got %h expected 00000011", bus.hi_out); else passed++;
        total++; if (bus.lo_out !== 32'h22) $display("FAIL dz_lo_hold: got %h expected 00000022", bus.lo_out); else passed++;
        @(posedge clk);
        #1;
        total++; if (bus.div_zero_exc !== 1'b0) $display("FAIL dz_pulse: got %b expected 0", bus.div_zero_exc); else passed++;
    endtask

    task automatic test_boundary;
        int k;
        launch(2'b00, 32'h8000_0000, 32'h8000_0000);
        wait_done(k);
        total++; if (bus.hi_out !== 32'h4000_0000) $display("FAIL minmul_hi: got %h expected 40000000", bus.hi_out); else passed++;
        total++; if (bus.lo_out !== 32'h0) $display("FAIL minmul_lo: got %h expected 00000000", bus.lo_out); else passed++;
        launch(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(k);
        total++; if (bus.lo_out !== 32'h8000_0000) $display("FAIL ovf_lo: got %h expected 80000000", bus.lo_out); else passed++;
        total++; if (bus.hi_out !== 32'h0) $display("FAIL ovf_hi: got %h expected 00000000", bus.hi_out); else passed++;
        total++; if (bus.div_zero_exc !== 1'b0) $display("FAIL ovf_dz: got %b expected 0", bus.div_zero_exc); else passed++;
    endtask

    task automatic test_abort;
        int   k;
        int   dones;
        logic busy9;
        launch(2'b01, 32'd100, 32'd7);
        busy9 = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) begin
                bus.start = 1'b1;
                bus.op    = 2'b00;
                bus.a_in  = 32'd3;
                bus.b_in  = 32'd3;
            end
            if (i == 6) bus.start = 1'b0;
            if (i == 9) busy9 = bus.busy;
        end
        total++; if (busy9 !== 1'b1) $display("FAIL abort_busy_pre: got %b expected 1", busy9); else passed++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", bus.busy); else passed++;
        total++; if (bus.hi_out !== 32'h0) $display("FAIL abort_hi: got %h expected 00000000", bus.hi_out); else passed++;
        total++; if (bus.lo_out !== 32'h0) $display("FAIL abort_lo: got %h expected 00000000", bus.lo_out); else passed++;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dones++;
            @(posedge clk);
            #1;
        end
        total++; if (dones !== 0) $display("FAIL abort_no_done: got %0d expected 0", dones); else passed++;
        launch(2'b01, 32'd100, 32'd7);
        wait_done(k);
        total++; if (k !== 33) $display("FAIL rerun_latency: got %0d expected 33", k); else passed++;
        total++; if (bus.lo_out !== 32'd14) $display("FAIL rerun_lo: got %h expected 0000000e", bus.lo_out); else passed++;
        total++; if (bus.hi_out !== 32'd2) $display("FAIL rerun_hi: got %h expected 00000002", bus.hi_out); else passed++;
    endtask

    task automatic test_unsigned_op;
        int          k;
        logic [31:0] exp_lo, exp_hi;
`ifdef MULTDIV_UNSIGNED_EN
        exp_lo = 32'h7FFF_FFFF;
        exp_hi = 32'h0000_0001;
`else
        exp_lo = 32'h0000_0000;
        exp_hi = 32'hFFFF_FFFF;
`endif
        launch(2'b11, 32'hFFFF_FFFF, 32'd2);
        wait_done(k);
        total++; if (k !== 33) $display("FAIL op11_latency: got %0d expected 33", k); else passed++;
        total++; if (bus.lo_out !== exp_lo) $display("FAIL op11_lo: got %h expected %h", bus.lo_out, exp_lo); else passed++;
        total++; if (bus.hi_out !== exp_hi) $display("FAIL op11_hi: got %h expected %h", bus.hi_out, exp_hi); else passed++;
    endtask

    task automatic test_back_to_back;
        int k;
        launch(2'b00, 32'd6, 32'd7);
        wait_done(k);
        total++; if (bus.lo_out !== 32'd42) $display("FAIL b2b_mul_lo: got %h expected 0000002a", bus.lo_out); else passed++;
        total++; if (bus.hi_out !== 32'd0) $display("FAIL b2b_mul_hi: got %h expected 00000000", bus.hi_out); else passed++;
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a_in  = 32'd42;
        bus.b_in  = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) $display("FAIL b2b_accept: got %b expected 1", bus.busy); else passed++;
        wait_done(k);
        total++; if (k !== 33) $display("FAIL b2b_latency: got %0d expected 33", k); else passed++;
        total++; if (bus.lo_out !== 32'd8) $display("FAIL b2b_div_lo: got %h expected 00000008", bus.lo_out); else passed++;
        total++; if (bus.hi_out !== 32'd2) $display("FAIL b2b_div_hi: got %h expected 00000002", bus.hi_out); else passed++;
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a_in  = '0;
        bus.b_in  = '0;
        test_reset();
        test_mult_latency();
        test_div_signed();
        test_div_zero();
        test_boundary();
        test_abort();
        test_unsigned_op();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
